// File: rtl/window_eval_sched.sv
// Shares one WIN_LEN-sample ones-count window evaluator among N_REQ channels.
// A granted channel runs cfg_windows back-to-back windows; round-robin picks the next owner.
module window_eval_sched #(
  parameter int N_REQ   = 4,
  parameter int WIN_LEN = 3,
  parameter int TARGET  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         w,
  input  logic [3:0]               cfg_windows,
  output logic [N_REQ-1:0]         grant,
  output logic                     busy,
  output logic                     win_valid,
  output logic                     win_match,
  output logic [$clog2(N_REQ)-1:0] win_owner,
  output logic                     done
);

  localparam int OW = $clog2(N_REQ);
  localparam int IW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int CW = $clog2(WIN_LEN + 1);

  typedef enum logic {IDLE, SAMPLE} state_t;

  state_t           state_q, state_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    last_q, last_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    ones_q, ones_d;
  logic [3:0]       left_q, left_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             vld_q, vld_d;
  logic             match_q, match_d;
  logic [OW-1:0]    wown_q, wown_d;
  logic             done_q, done_d;

  logic             pick_found;
  logic [OW-1:0]    pick_idx;
  logic [OW-1:0]    cand_idx;
  logic [CW:0]      sum_w;

  // Round-robin scan starting just after the previous owner, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand_idx = OW'((int'(last_q) + i) % N_REQ);
      if (!pick_found && req[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  assign sum_w = {1'b0, ones_q} + (CW+1)'(w[owner_q]);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    idx_d   = idx_q;
    ones_d  = ones_q;
    left_d  = left_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    vld_d   = 1'b0;
    match_d = 1'b0;
    wown_d  = wown_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = SAMPLE;
          owner_d = pick_idx;
          grant_d = N_REQ'(1) << pick_idx;
          busy_d  = 1'b1;
          idx_d   = '0;
          ones_d  = '0;
          left_d  = (cfg_windows == 4'd0) ? 4'd1 : cfg_windows;
        end
      end
      SAMPLE: begin
        if (idx_q == IW'(WIN_LEN - 1)) begin
          vld_d   = 1'b1;
          match_d = (sum_w == (CW+1)'(TARGET));
          wown_d  = owner_q;
          idx_d   = '0;
          ones_d  = '0;
          if (left_q > 4'd1) begin
            left_d = left_q - 4'd1;
          end else begin
            grant_d = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            last_d  = owner_q;
            state_d = IDLE;
          end
        end else begin
          idx_d  = idx_q + IW'(1);
          ones_d = CW'(sum_w);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= OW'(N_REQ - 1);
      idx_q   <= '0;
      ones_q  <= '0;
      left_q  <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
      match_q <= 1'b0;
      wown_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      ones_q  <= ones_d;
      left_q  <= left_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      vld_q   <= vld_d;
      match_q <= match_d;
      wown_q  <= wown_d;
      done_q  <= done_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = busy_q;
  assign win_valid = vld_q;
  assign win_match = match_q;
  assign win_owner = wown_q;
  assign done      = done_q;

endmodule

// File: tb/tb_window_eval_sched.sv
// Bench for window_eval_sched: sample-queue reference model compared every cycle,
// directed literal scenarios, and a WIN_LEN=1/TARGET=0 instance for the boundary case.
module tb_window_eval_sched;

  localparam int NR = 4;
  localparam int WL = 3;
  localparam int TG = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NR-1:0] req = '0;
  logic [NR-1:0] w = '0;
  logic [3:0]    cfg = 4'd1;
  logic [NR-1:0] grant;
  logic          busy, win_valid, win_match, done;
  logic [1:0]    win_owner;

  logic [1:0] req1 = '0;
  logic [1:0] w1 = '0;
  logic [3:0] cfg1 = 4'd0;
  logic [1:0] grant1;
  logic       busy1, vld1, match1, done1;
  logic [0:0] owner1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  window_eval_sched #(.N_REQ(NR), .WIN_LEN(WL), .TARGET(TG)) u_dut (
    .clk(clk), .reset(reset), .req(req), .w(w), .cfg_windows(cfg),
    .grant(grant), .busy(busy), .win_valid(win_valid), .win_match(win_match),
    .win_owner(win_owner), .done(done)
  );

  window_eval_sched #(.N_REQ(2), .WIN_LEN(1), .TARGET(0)) u_dut1 (
    .clk(clk), .reset(reset), .req(req1), .w(w1), .cfg_windows(cfg1),
    .grant(grant1), .busy(busy1), .win_valid(vld1), .win_match(match1),
    .win_owner(owner1), .done(done1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: grant bookkeeping plus a queue of collected samples per window.
  int            m_last = NR - 1;
  bit            m_busy = 0;
  int            m_ch = 0;
  int            m_nwin = 0;
  int            m_smp[$];
  int            mc, msum;
  bit            mfound;
  logic [NR-1:0] e_grant = '0;
  bit            e_vld = 0, e_match = 0, e_done = 0;
  int            e_owner = 0;

  always @(posedge clk) begin
    e_vld = 0; e_match = 0; e_done = 0;
    if (!reset) begin
      m_busy = 0; e_grant = '0; m_last = NR - 1; m_smp.delete(); e_owner = 0;
    end else if (!m_busy) begin
      mfound = 0;
      for (int i = 1; i <= NR; i++) begin
        mc = (m_last + i) % NR;
        if (!mfound && req[mc]) begin
          mfound = 1;
          m_ch = mc;
        end
      end
      if (mfound) begin
        m_busy = 1;
        m_nwin = (cfg == 0) ? 1 : int'(cfg);
        m_smp.delete();
        e_grant = '0;
        e_grant[m_ch] = 1'b1;
      end
    end else begin
      m_smp.push_back(int'(w[m_ch]));
      if (m_smp.size() == WL) begin
        msum = 0;
        foreach (m_smp[j]) msum += m_smp[j];
        e_vld = 1;
        e_match = (msum == TG);
        e_owner = m_ch;
        m_smp.delete();
        m_nwin--;
        if (m_nwin == 0) begin
          m_busy = 0; e_grant = '0; e_done = 1; m_last = m_ch;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("grant", grant, e_grant);
    check("busy", busy, m_busy);
    check("win_valid", win_valid, e_vld);
    check("win_match", win_match, e_match);
    check("done", done, e_done);
    if (e_vld) check("win_owner", win_owner, e_owner);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req = '0;
    for (int i = 0; i < 40 && busy; i++) cyc();
    check("drain_idle", busy, 1'b0);
    cyc();
  endtask

  int order[$];
  logic [NR-1:0] prev_g;

  initial begin
    reset = 1'b0;
    cyc(); cyc();
    check("rst_grant", grant, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_owner", win_owner, 2'd0);
    reset = 1'b1;
    cyc(); cyc();

    // Single channel, w0 = 1,0,1 -> match
    req = 4'b0001; cfg = 4'd1; w = 4'b0000;
    cyc(); req = '0;
    check("t1_grant_a", grant, 4'b0001); w = 4'b0001;
    cyc(); check("t1_grant_b", grant, 4'b0001); w = 4'b0000;
    cyc(); check("t1_grant_c", grant, 4'b0001); w = 4'b0001;
    cyc();
    check("t1_vld", win_valid, 1'b1);
    check("t1_match", win_match, 1'b1);
    check("t1_owner", win_owner, 2'd0);
    check("t1_done", done, 1'b1);
    check("t1_grant_off", grant, 4'b0000);
    drain();

    // Three windows on channel 2, all ones -> no matches
    req = 4'b0100; cfg = 4'd3; w = 4'b0100;
    cyc(); req = '0;
    for (int i = 0; i < 9; i++) begin
      check("t2_grant", grant, 4'b0100);
      if (i == 3 || i == 6) begin
        check("t2_vld", win_valid, 1'b1);
        check("t2_match", win_match, 1'b0);
        check("t2_done_early", done, 1'b0);
      end
      cyc();
    end
    check("t2_vld_last", win_valid, 1'b1);
    check("t2_match_last", win_match, 1'b0);
    check("t2_done", done, 1'b1);
    check("t2_grant_off", grant, 4'b0000);
    drain();

    // Round-robin from reset with all channels requesting
    reset = 1'b0; cyc(); reset = 1'b1;
    req = 4'b1111; cfg = 4'd1; prev_g = '0;
    for (int i = 0; i < 40 && order.size() < 5; i++) begin
      cyc();
      if (grant != 0 && grant != prev_g)
        for (int k = 0; k < NR; k++) if (grant[k]) order.push_back(k);
      prev_g = grant;
    end
    check("rr_count", order.size(), 5);
    if (order.size() == 5) begin
      check("rr_0", order[0], 0);
      check("rr_1", order[1], 1);
      check("rr_2", order[2], 2);
      check("rr_3", order[3], 3);
      check("rr_4", order[4], 0);
    end
    drain();

    // Reset after the 2nd sample aborts the window
    req = 4'b0001; cfg = 4'd1; w = 4'b0001;
    cyc(); req = '0;
    cyc();
    cyc(); reset = 1'b0;
    cyc();
    check("rs_grant", grant, 4'b0000);
    check("rs_vld", win_valid, 1'b0);
    check("rs_done", done, 1'b0);
    check("rs_busy", busy, 1'b0);
    reset = 1'b1; req = 4'b0110;
    cyc();
    check("rs_regrant", grant, 4'b0010);
    drain();

    // WIN_LEN=1, TARGET=0, cfg_windows=0 behaves as 1
    req1 = 2'b01; cfg1 = 4'd0; w1 = 2'b00;
    cyc(); check("b_grant_a", grant1, 2'b01);
    cyc();
    check("b_vld0", vld1, 1'b1);
    check("b_match0", match1, 1'b1);
    check("b_done0", done1, 1'b1);
    check("b_gap", grant1, 2'b00);
    w1 = 2'b01;
    cyc(); check("b_grant_b", grant1, 2'b01);
    cyc();
    check("b_vld1", vld1, 1'b1);
    check("b_match1", match1, 1'b0);
    req1 = '0;
    cyc(); cyc();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      req   = ($urandom_range(0, 2) == 0) ? NR'($urandom) : '0;
      w     = NR'($urandom);
      cfg   = 4'($urandom_range(0, 3));
      reset = ($urandom_range(0, 299) != 0);
      cyc();
    end
    reset = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/window_eval_sched.md
Name: window_eval_sched

Overview:
- Shares one w-sample window evaluator among N_REQ requester channels using round-robin arbitration.
- A granted channel has its w line sampled over cfg_windows back-to-back windows of WIN_LEN cycles each.
- At the end of every window the block reports whether the count of 1s equals TARGET.
- Sits between the per-channel start/observe logic and downstream result consumers; one channel is evaluated at a time.

Parameters:
N_REQ, 4, number of requester channels (2..8)
WIN_LEN, 3, samples per window (>=1)
TARGET, 2, exact ones-count that produces a match (0..WIN_LEN)

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-low reset
req  input  N_REQ  per-channel evaluation request, level
w  input  N_REQ  per-channel sample input
cfg_windows  input  4  windows per grant; 0 treated as 1
grant  output  N_REQ  one-hot grant, registered
busy  output  1  high while any grant is active
win_valid  output  1  one-cycle pulse: window result available
win_match  output  1  window ones-count == TARGET; valid with win_valid, 0 otherwise
win_owner  output  clog2(N_REQ)  channel index of the reported window
done  output  1  one-cycle pulse: last window of grant reported, grant released

Behaviour:
- Reset (reset==0 at an edge):
  - grant, busy, win_valid, win_match, win_owner, done are all 0.
  - FSM goes to IDLE; sample index and ones count go to 0.
  - Round-robin pointer last_owner = N_REQ-1, so channel 0 has top priority.
  - Reset mid-window aborts the window with no result pulse.
- IDLE:
  - If req != 0 in cycle t, pick the first set bit scanning from (last_owner+1) mod N_REQ upward with wrap.
  - At edge end of t: grant[k]=1, busy=1, state=SAMPLE, idx=0, ones=0, win_left=max(cfg_windows,1).
  - cfg_windows is sampled only at this edge; later changes are ignored for this grant.
  - If req==0, stay in IDLE.
- SAMPLE:
  - Each cycle, w[k] is sampled; ones accumulates.
  - ones width is clog2(WIN_LEN+1); the count cannot overflow.
  - In the cycle with idx==WIN_LEN-1 (last sample), the next edge sets:
    - win_valid=1, win_owner=k, win_match=((ones + w[k])==TARGET);
    - idx=0 and ones=0.
  - If win_left>1: decrement win_left and keep sampling the next cycle with no gap; grant stays high.
  - If win_left==1: set grant=0, busy=0, done=1 (same cycle as the final win_valid), last_owner=k, state=IDLE.
- Latency:
  - req seen in cycle t -> grant from t+1.
  - Samples are taken in t+1..t+WIN_LEN; first win_valid is in t+WIN_LEN+1.
- Arbitration timing: it happens only in IDLE. After a release there is at least one cycle with grant==0, the cycle carrying done, and arbitration occurs in that cycle.
- req rules:
  - Deasserting req[k] during a grant has no effect; all configured windows complete.
  - req of other channels is ignored while busy.
- Simultaneous requests are resolved strictly by the round-robin order above. A channel holding req continuously is served again only after every other requesting channel has had a grant.
- win_valid and done are single-cycle pulses. win_match is 0 whenever win_valid is 0.

Test Plan:
- Single channel, default params: req=0001 at cycle 5, cfg_windows=1, w0 = 1,0,1 in cycles 6,7,8.
  - Expect grant=0001 in cycles 6–8.
  - Expect win_valid=1, win_match=1, win_owner=0, done=1 in cycle 9; grant=0000 in cycle 9.
- Multi-window, all ones: cfg_windows=3 on channel 2, w2 held 1 for 9 cycles.
  - Expect win_valid pulses 3 cycles apart, each with win_match=0 (count 3 != 2).
  - Expect done only with the third pulse and grant high for 9 consecutive cycles.
- Round-robin: req=1111 held, cfg_windows=1.
  - Grant order 0,1,2,3,0 with a 1-cycle gap between grants.
  - win_owner sequence matches the grant order.
- Boundary values: cfg_windows=0 behaves as 1. WIN_LEN=1, TARGET=0: w=0 gives match=1 and w=1 gives match=0.
- Reset mid-window: assert reset after the 2nd sample.
  - No win_valid or done is produced; all outputs are 0 at the next edge.
  - After release, req=0110 grants channel 1 first because the pointer was reset.
- Request drop mid-grant: req0 drops after the first sample. The window still completes and reports normally, and done is produced.
